// File: rtl/dmem_pkg.sv
// Shared types and helpers for the big-endian byte-addressed data memory.
// Response words up to DMEM_MAX_W bits are carried in dmem_rsp_t.
package dmem_pkg;

  localparam int DMEM_MAX_W = 64;

  typedef struct packed {
    logic [DMEM_MAX_W-1:0] rdata;
    logic                  err;
  } dmem_rsp_t;

  function automatic int dmem_nb(input int word_w);
    return word_w / 8;
  endfunction

  // True when addr is word aligned and the whole word lies inside the store.
  function automatic logic dmem_addr_ok(input logic [63:0] addr, input int depth, input int nb);
    logic [63:0] d;
    logic [63:0] n;
    d = 64'(depth);
    n = 64'(nb);
    return ((addr % n) == 64'd0) && (d >= n) && (addr <= (d - n));
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// NB parallel byte-wide banks; lane k (k=0 is the MSB lane) holds byte word*NB+k.
// Per-lane write enables (be order: bit NB-1 is lane 0), synchronous read.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_W      = 32,
  parameter     INIT_FILE   = "",
  localparam int NB         = dmem_nb(WORD_W),
  localparam int WORDS      = DEPTH_BYTES / NB,
  localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic [NB-1:0]     we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] bank [WORDS];
    logic [7:0] rd_p1;

    always_ff @(posedge clk) begin
      if (we[NB-1-k]) bank[idx] <= wdata[WORD_W-1-8*k -: 8];
      if (re)         rd_p1     <= bank[idx];
    end

    assign rdata[WORD_W-1-8*k -: 8] = rd_p1;
  end

endmodule

// File: rtl/dmem_bank.sv
// Data memory with valid/ready request/response handshake, one-entry response
// stage, alignment/range checking and a sticky first-error record.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter     INIT_FILE   = "",
  localparam int NB         = dmem_nb(WORD_W),
  localparam int WORDS      = DEPTH_BYTES / NB,
  localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              err_clr,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr
);

  logic              acc_p0;
  logic              ok_p0;
  logic [NB-1:0]     we_p0;
  logic              re_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [WORD_W-1:0] rd_word_p1;
  logic              rsp_vld_p1;
  logic              rsp_err_p1;
  logic              rsp_rd_p1;
  dmem_rsp_t         rsp_p1;

  // ---- p0: request acceptance and address check ----
  assign req_ready = rst_n & (~rsp_vld_p1 | rsp_ready);
  assign acc_p0    = req_valid & req_ready;
  assign ok_p0     = dmem_addr_ok(64'(req_addr), DEPTH_BYTES, NB);
  assign we_p0     = (acc_p0 & req_wr & ok_p0) ? req_be : '0;
  assign re_p0     = acc_p0 & ~req_wr & ok_p0;
  assign idx_p0    = IDX_W'(req_addr / ADDR_W'(NB));

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WORD_W      (WORD_W),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (we_p0),
    .re    (re_p0),
    .idx   (idx_p0),
    .wdata (req_wdata),
    .rdata (rd_word_p1)
  );

  // ---- p1: response register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 1'b0;
      rsp_err_p1 <= 1'b0;
      rsp_rd_p1  <= 1'b0;
    end else if (acc_p0) begin
      rsp_vld_p1 <= 1'b1;
      rsp_err_p1 <= ~ok_p0;
      rsp_rd_p1  <= ~req_wr & ok_p0;
    end else if (rsp_ready) begin
      rsp_vld_p1 <= 1'b0;
    end
  end

  // A new error in the same cycle as a clear takes precedence over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (acc_p0 & ~ok_p0 & (~err_sticky | err_clr)) begin
      err_sticky <= 1'b1;
      err_addr   <= req_addr;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  // The array read register only moves on an accepted good read, so gating it
  // here keeps write/error responses at zero and stalled responses stable.
  always_comb begin
    rsp_p1 = '0;
    if (rsp_vld_p1 & rsp_rd_p1) rsp_p1.rdata = DMEM_MAX_W'(rd_word_p1);
    rsp_p1.err = rsp_vld_p1 & rsp_err_p1;
  end

  assign rsp_valid = rsp_vld_p1;
  assign rsp_rdata = WORD_W'(rsp_p1.rdata);
  assign rsp_err   = rsp_p1.err;

endmodule

// File: tb/tb_dmem_bank.sv
// Scoreboard bench for dmem_bank: a flat byte-array model predicts each
// response at acceptance; a monitor compares whenever a response is presented.
module tb_dmem_bank;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        err_clr = 1'b0;
  logic        err_sticky;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  dmem_bank #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .WORD_W(32), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_clr(err_clr), .err_sticky(err_sticky), .err_addr(err_addr)
  );

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        q[$];
  logic [7:0]  mem [DEPTH];
  logic        m_s = 1'b0;
  logic [31:0] m_ea = '0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          rr_rand = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour of one clock edge, given whether a request was taken.
  function automatic void model_edge(input bit acc, input bit clr);
    bit   bad;
    exp_t e;
    if (acc) begin
      bad = (req_addr % 4 != 0) || (req_addr > DEPTH - 4);
      e.rdata = '0;
      e.err   = bad;
      if (!bad) begin
        if (req_wr) begin
          for (int k = 0; k < 4; k++)
            if (req_be[3-k]) mem[req_addr + k] = req_wdata[31-8*k -: 8];
        end else begin
          e.rdata = {mem[req_addr], mem[req_addr+1], mem[req_addr+2], mem[req_addr+3]};
        end
      end
      q.push_back(e);
      if (bad && (!m_s || clr)) begin
        m_s  = 1'b1;
        m_ea = req_addr;
      end else if (clr) m_s = 1'b0;
    end else if (clr) m_s = 1'b0;
  endfunction

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit clr);
    int n;
    bit acc;
    n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be;
    err_clr = clr;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      model_edge(acc, clr);
      if (acc) break;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: addr %h not accepted within 50 cycles", addr);
        break;
      end
    end
    req_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      err_clr = clr;
      @(posedge clk);
      #1;
      model_edge(1'b0, clr);
    end
    err_clr = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: peek at the head while stalled (stability), pop on consumption.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_err_sticky", 32'(err_sticky), 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
    end else begin
      chk("req_ready_rule", 32'(req_ready), 32'(!rsp_valid || rsp_ready));
      chk("err_sticky", 32'(err_sticky), 32'(m_s));
      chk("err_addr", err_addr, m_ea);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rdata %h err %0d, expected no response", rsp_rdata, rsp_err);
        end else begin
          chk("rsp_rdata", rsp_rdata, q[0].rdata);
          chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < DEPTH / 4; w++) issue(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);

    // Full word then byte-enable merge on address 8.
    issue(1'b1, 32'd8, 32'hDEADBEEF, 4'b1111, 1'b0);
    issue(1'b0, 32'd8, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 32'd8, 32'h11223344, 4'b0101, 1'b0);
    issue(1'b0, 32'd8, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 32'd12, 32'h55667788, 4'b0000, 1'b0);
    issue(1'b0, 32'd12, 32'h0, 4'h0, 1'b0);

    // Misaligned write, out-of-range read, then clear racing a new error.
    issue(1'b1, 32'd6, 32'hFFFFFFFF, 4'hF, 1'b0);
    issue(1'b0, 32'd4, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 32'd1024, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 32'd1020, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 32'd1021, 32'h0, 4'h0, 1'b1);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Backpressure: hold a read of 0 for several cycles with a second queued.
    rsp_ready = 1'b1;
    idle(1, 1'b0);
    rsp_ready = 1'b0;
    issue(1'b0, 32'd0, 32'h0, 4'h0, 1'b0);
    fork
      issue(1'b0, 32'd4, 32'h0, 4'h0, 1'b0);
    join_none
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait fork;

    // Randomized traffic with random response backpressure and clears.
    rr_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
      else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) | 32'd1;
      else if (r == 8) a = 32'(DEPTH - 4 + $urandom_range(0, 3));
      else             a = 32'(DEPTH + $urandom_range(0, 300));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 7) == 0);
    end
    rr_rand = 1'b0;
    rsp_ready = 1'b1;
    idle(2, 1'b0);

    // Reset with a response pending; storage must survive.
    issue(1'b1, 32'd16, 32'hCAFEF00D, 4'hF, 1'b0);
    issue(1'b0, 32'd16, 32'h0, 4'h0, 1'b0);
    rsp_ready = 1'b0;
    idle(2, 1'b0);
    rst_n = 1'b0;
    q.delete();
    m_s = 1'b0;
    m_ea = '0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b0, 32'd16, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 32'd8, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
